spi_regfile: RTL

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 slave front end to a bank of NREG 8-bit configuration registers.
// Writes land in a shadow copy and are committed to cfg_vec atomically when chip select
// rises. Optional build macro SPI_REGFILE_READBACK_EN adds a MISO shifter for register
// readback; without it spi_miso is tied low.
module spi_regfile #(
  parameter int unsigned             NREG      = 8,
  parameter logic [NREG*8-1:0]       RESET_VAL = {NREG{8'h00}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NREG*8-1:0] cfg_vec,
  output logic              cfg_update,
  output logic              busy
);

  typedef enum logic [1:0] {StWaitCs, StIdle, StCmd, StData} state_e;

  logic csn_meta_q, csn_sync_q, csn_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // Two-flop synchronizers plus one history flop for edge detection; reset to idle bus levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_meta_q  <= 1'b1;
      csn_sync_q  <= 1'b1;
      csn_prev_q  <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      csn_meta_q  <= spi_csn;
      csn_sync_q  <= csn_meta_q;
      csn_prev_q  <= csn_sync_q;
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic csn_rise, csn_fall, sclk_rise;
  assign csn_rise  = csn_sync_q & ~csn_prev_q;
  assign csn_fall  = ~csn_sync_q & csn_prev_q;
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;

  state_e            state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [6:0]        addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              got_byte_q, got_byte_d;
  logic [NREG*8-1:0] shadow_q, shadow_d;
  logic [NREG*8-1:0] cfg_q, cfg_d;
  logic              upd_q, upd_d;

  logic [7:0] rx_next;
  logic       byte_done;
  logic       addr_in_range;
  logic [6:0] addr_next;

  assign rx_next       = {rx_q[6:0], mosi_sync_q};
  assign byte_done     = sclk_rise && (bit_cnt_q == 3'd7);
  assign addr_in_range = ({1'b0, addr_q} < 8'(NREG));

  // Address advance: wrap inside the bank, saturate at 127 outside it.
  always_comb begin
    addr_next = addr_q + 7'd1;
    if (addr_in_range) begin
      if ({1'b0, addr_q} == 8'(NREG - 1)) addr_next = 7'd0;
    end else if (addr_q == 7'd127) begin
      addr_next = 7'd127;
    end
  end

  // Frame FSM: command decode, shadow writes, commit on chip-select release.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    got_byte_d = got_byte_q;
    shadow_d   = shadow_q;
    cfg_d      = cfg_q;
    upd_d      = 1'b0;

    unique case (state_q)
      StWaitCs: begin
        // Synchronizer contents are forced high by reset; let them flush before trusting csn.
        shadow_d = cfg_q;
        if (settle_q != 2'd3) begin
          settle_d = settle_q + 2'd1;
        end else if (csn_sync_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        shadow_d   = cfg_q;
        bit_cnt_d  = 3'd0;
        got_byte_d = 1'b0;
        if (csn_fall) state_d = StCmd;
      end
      StCmd: begin
        if (csn_rise) begin
          state_d = StIdle;
        end else if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            wr_d    = rx_next[7];
            addr_d  = rx_next[6:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (csn_rise) begin
          state_d = StIdle;
          if (wr_q && got_byte_q) begin
            cfg_d = shadow_q;
            upd_d = 1'b1;
          end else begin
            shadow_d = cfg_q;
          end
        end else if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            if (wr_q && addr_in_range) begin
              shadow_d[8*int'(addr_q) +: 8] = rx_next;
              got_byte_d                    = 1'b1;
            end
            addr_d = addr_next;
          end
        end
      end
      default: state_d = StWaitCs;
    endcase
  end

  // Frame state and register storage; reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitCs;
      settle_q   <= 2'd0;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      addr_q     <= 7'd0;
      wr_q       <= 1'b0;
      got_byte_q <= 1'b0;
      shadow_q   <= RESET_VAL;
      cfg_q      <= RESET_VAL;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      got_byte_q <= got_byte_d;
      shadow_q   <= shadow_d;
      cfg_q      <= cfg_d;
      upd_q      <= upd_d;
    end
  end

  assign cfg_vec    = cfg_q;
  assign cfg_update = upd_q;
  assign busy       = (state_q == StCmd) || (state_q == StData);

`ifdef SPI_REGFILE_READBACK_EN
  logic       sclk_fall;
  logic [7:0] tx_q, tx_d;
  logic       tx_skip_q, tx_skip_d;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

  // Register to present next: the command's start address, or the post-increment address.
  always_comb begin
    rd_addr = (state_q == StCmd) ? rx_next[6:0] : addr_next;
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < 8'(NREG)) rd_data = cfg_q[8*int'(rd_addr) +: 8];
  end

  // MISO shifter: load on the last sampled bit, hold over the trailing fall of that bit,
  // then shift once per later fall so bit7 is stable for the master's first sample.
  always_comb begin
    tx_d      = tx_q;
    tx_skip_d = tx_skip_q;
    if (((state_q == StCmd) || (state_q == StData)) && !csn_rise) begin
      if (byte_done && (((state_q == StCmd) && !rx_next[7]) ||
                        ((state_q == StData) && !wr_q))) begin
        tx_d      = rd_data;
        tx_skip_d = 1'b1;
      end else if (sclk_fall && (state_q == StData)) begin
        if (tx_skip_q) tx_skip_d = 1'b0;
        else           tx_d      = {tx_q[6:0], 1'b0};
      end
    end else begin
      tx_d      = 8'h00;
      tx_skip_d = 1'b0;
    end
  end

  // MISO shifter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q      <= 8'h00;
      tx_skip_q <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      tx_skip_q <= tx_skip_d;
    end
  end

  assign spi_miso = (state_q == StData) & tx_q[7];
`else
  assign spi_miso = 1'b0;
`endif

endmodule
